mmio_port_controller: RTL and testbench
=======================================

// Module: mmio_port_controller
// PURPOSE
//  Memory-mapped I/O port unit on the MIPS_Processor data bus, in parallel with DataMemory.
//  Decodes the MMIO window and holds the 32-bit output port register, which drives PortOut.
//  Synchronises and debounces the 8-bit PortIn and presents it as a readable register.
//  Hit steers the processor's load mux between DataMemory and this block.
// PARAMETERS
//  MMIO_BASE        32'hFFFF_0000  word-aligned base of the 16-byte register window
//  DEBOUNCE_CYCLES  16             consecutive stable clocks required to accept a PortIn change (>=1)
//  CNT_WIDTH        8              debounce counter width; 2**CNT_WIDTH > DEBOUNCE_CYCLES
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  Address     in   32  byte address from ALUResult (unmodified, pre data-memory offset)
//  WriteData   in   32  store data (ReadData2)
//  MemWrite    in   1   store strobe from Control
//  MemRead     in   1   load strobe from Control
//  PortIn      in   8   asynchronous external inputs
//  ReadData    out  32  load data; combinational
//  Hit         out  1   Address[31:4]==MMIO_BASE[31:4] && Address[1:0]==0; combinational
//  PortOut     out  32  output port register
//  ChangeFlag  out  1   mirror of STATUS[0]
// BEHAVIOUR
//  Register map (offset = Address[3:2]):
//   0x0 PORT_OUT  R/W  32-bit
//   0x4 PORT_IN   RO   {24'b0, stable_in}
//   0x8 STATUS    bit0 change (W1C), bit1 debounce_busy (RO); other bits read 0
//   0xC reserved  reads 0; writes ignored
//  Reset (async, on assertion):
//   PortOut=0, stable_in=0, sync flops=0, counter=0, change=0.
//   Reset applied mid-debounce discards the pending change.
//  Writes:
//   - Take effect at the rising clk edge when MemWrite && Hit; PortOut updates one cycle later.
//   - Writes to PORT_IN are ignored.
//   - Writes to STATUS clear bit0 only where WriteData[0]=1.
//  Reads:
//   - ReadData = selected register when MemRead && Hit, else 32'h0.
//   - Zero-cycle latency; no wait states and no handshake.
//  Unaligned or out-of-window addresses: Hit=0, no state change, ReadData=0.
//  Input path:
//   - PortIn passes through a 2-flop synchroniser to give sync_in.
//   - Debounce FSM, states IDLE and COUNT:
//     IDLE : sync_in==stable_in -> stay, counter=0.
//            sync_in!=stable_in -> COUNT, counter=1.
//     COUNT: sync_in==stable_in -> IDLE, counter=0 (glitch rejected).
//            sync_in changed to a value different from the one being counted -> counter=1, stay.
//            counter==DEBOUNCE_CYCLES-1 and sync_in unchanged -> stable_in<=sync_in, change<=1,
//              counter=0, IDLE.
//            otherwise -> counter++.
//   - DEBOUNCE_CYCLES=1: a differing sync_in is accepted at the first edge, with no COUNT state.
//   - debounce_busy = (state==COUNT).
//   - Latency from a PortIn transition to PORT_IN update: 2+DEBOUNCE_CYCLES rising edges.
//   - The counter saturates and never wraps; the parameter rule guarantees this.
//  Simultaneous events:
//   - STATUS W1C in the same cycle as a new change event: set wins, change stays 1.
//   - PORT_OUT write and read in the same cycle: the read returns the old value.
// STRUCTURE
//  Package mmio_pkg:
//   - MMIO_BASE default, offset constants OFF_PORT_OUT/OFF_PORT_IN/OFF_STATUS.
//   - STATUS bit indices.
//   - Debounce state localparams.
//  Sub-module input_debouncer (WIDTH=8): synchroniser, FSM and counter; outputs stable_in,
//   change_pulse and busy.
//  Top level: address decode, PORT_OUT and change registers, read mux.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 Write 0xFFFF0000 <- 0x000000A5 -> PortOut=0xA5 after the edge; read of 0xFFFF0000 returns 0xA5.
//  2 PortIn 0x00->0x3C held -> PORT_IN reads 0 at edge 5 and 0x3C at edge 6; STATUS=0x1, ChangeFlag=1.
//  3 PortIn pulse 0x01 held 3 cycles then back to 0 -> PORT_IN stays 0, change stays 0,
//    busy seen high for 3 cycles.
//  4 Write STATUS <- 0x1 on the same edge the debouncer accepts a new value -> change remains 1;
//    a later W1C clears it to 0.
//  5 Assert reset during COUNT with PortOut=0xFF -> PortOut=0, PORT_IN=0, busy=0 immediately,
//    without waiting for clk.
//  6 Write to 0x10010000 and to 0xFFFF0002 with MemWrite=1 -> Hit=0, PortOut unchanged, ReadData=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants, register offsets and debounce state encoding for the MMIO port unit.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT       = 32'hFFFF_0000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int unsigned CNT_WIDTH_DEFAULT       = 8;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PORT_IN_W = 8;
  localparam int unsigned OFF_W     = 2;

  localparam logic [OFF_W-1:0] OFF_PORT_OUT = 2'd0;
  localparam logic [OFF_W-1:0] OFF_PORT_IN  = 2'd1;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 2'd2;
  localparam logic [OFF_W-1:0] OFF_RESERVED = 2'd3;

  localparam int unsigned STATUS_CHANGE_BIT = 0;
  localparam int unsigned STATUS_BUSY_BIT   = 1;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } dbState_e;

  // Window hit: same 16-byte block as base and word aligned.
  function automatic logic inWindow(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:4] == base[31:4]) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mmio_port_controller_if.sv
// Processor data-bus view of the MMIO port unit (runs alongside DataMemory).
interface mmio_port_controller_if;
  import mmio_pkg::*;

  logic [DATA_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] ReadData;
  logic              Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );

endinterface

// File: rtl/mmio_port_controller_input_debouncer.sv
// Two-flop synchroniser plus counting debouncer; a new input value is accepted only
// after it has been seen unchanged on DEBOUNCE_CYCLES consecutive clocks.
module input_debouncer
  import mmio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] portIn,
  output logic [WIDTH-1:0] stableIn,
  output logic             changePulse_c,
  output logic             busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_COUNT  = '1;

  logic [WIDTH-1:0]     metaIn;
  logic [WIDTH-1:0]     syncIn;
  dbState_e             state;
  dbState_e             stateNext;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] counterNext;
  logic [WIDTH-1:0]     countVal;
  logic [WIDTH-1:0]     countValNext;
  logic [WIDTH-1:0]     stableNext;

  // Metastability guard for the asynchronous inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      metaIn <= '0;
      syncIn <= '0;
    end else begin
      metaIn <= portIn;
      syncIn <= metaIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= DB_IDLE;
      counter  <= '0;
      countVal <= '0;
      stableIn <= '0;
    end else begin
      state    <= stateNext;
      counter  <= counterNext;
      countVal <= countValNext;
      stableIn <= stableNext;
    end
  end

  always_comb begin
    stateNext     = state;
    counterNext   = counter;
    countValNext  = countVal;
    stableNext    = stableIn;
    changePulse_c = 1'b0;

    case (state)
      DB_IDLE: begin
        counterNext = '0;
        if (syncIn != stableIn) begin
          // A single-cycle debounce accepts immediately and never enters COUNT.
          if (DEBOUNCE_CYCLES == 1) begin
            stableNext    = syncIn;
            changePulse_c = 1'b1;
          end else begin
            stateNext    = DB_COUNT;
            counterNext  = CNT_WIDTH'(1);
            countValNext = syncIn;
          end
        end
      end

      DB_COUNT: begin
        if (syncIn == stableIn) begin
          stateNext   = DB_IDLE;
          counterNext = '0;
        end else if (syncIn != countVal) begin
          counterNext  = CNT_WIDTH'(1);
          countValNext = syncIn;
        end else if (counter == LAST_COUNT) begin
          stableNext    = syncIn;
          changePulse_c = 1'b1;
          counterNext   = '0;
          stateNext     = DB_IDLE;
        end else if (counter != MAX_COUNT) begin
          counterNext = counter + CNT_WIDTH'(1);
        end
      end

      default: begin
        stateNext   = DB_IDLE;
        counterNext = '0;
      end
    endcase
  end

  assign busy = (state == DB_COUNT);

endmodule

// File: rtl/mmio_port_controller.sv
// MMIO port unit: window decode, output port register, debounced input port and
// sticky change flag, with a zero-latency read mux for the processor load path.
module mmio_port_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE       = MMIO_BASE_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_port_controller_if.slave  bus,
  input  logic [PORT_IN_W-1:0]   PortIn,
  output logic [DATA_W-1:0]      PortOut,
  output logic                   ChangeFlag
);

  logic                 hitC;
  logic [OFF_W-1:0]     offset;
  logic                 wrEn;
  logic [PORT_IN_W-1:0] stableIn;
  logic                 changePulse_c;
  logic                 busy;
  logic                 changeReg;
  logic                 changeNext;
  logic [DATA_W-1:0]    readMux;

  input_debouncer #(
    .WIDTH           (PORT_IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_debouncer (
    .clk           (clk),
    .reset         (reset),
    .portIn        (PortIn),
    .stableIn      (stableIn),
    .changePulse_c (changePulse_c),
    .busy          (busy)
  );

  assign hitC   = inWindow(bus.Address, MMIO_BASE);
  assign offset = bus.Address[3:2];
  assign wrEn   = bus.MemWrite && hitC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut <= '0;
    end else if (wrEn && (offset == OFF_PORT_OUT)) begin
      PortOut <= bus.WriteData;
    end
  end

  // A new acceptance outranks a same-cycle write-one-to-clear.
  always_comb begin
    changeNext = changeReg;
    if (wrEn && (offset == OFF_STATUS) && bus.WriteData[STATUS_CHANGE_BIT]) begin
      changeNext = 1'b0;
    end
    if (changePulse_c) begin
      changeNext = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changeReg <= 1'b0;
    end else begin
      changeReg <= changeNext;
    end
  end

  assign ChangeFlag = changeReg;

  // Reads see pre-edge register contents, so a same-cycle write returns the old value.
  always_comb begin
    readMux = '0;
    case (offset)
      OFF_PORT_OUT: readMux = PortOut;
      OFF_PORT_IN:  readMux = DATA_W'(stableIn);
      OFF_STATUS: begin
        readMux[STATUS_CHANGE_BIT] = changeReg;
        readMux[STATUS_BUSY_BIT]   = busy;
      end
      OFF_RESERVED: readMux = '0;
      default:      readMux = '0;
    endcase
  end

  assign bus.ReadData = (bus.MemRead && hitC) ? readMux : '0;
  assign bus.Hit      = hitC;

endmodule

// File: tb/tb_mmio_port_controller.sv
// Bench for mmio_port_controller with DEBOUNCE_CYCLES=4: directed scenarios plus a
// randomized run against a sample-history reference model.
module tb_mmio_port_controller;

  localparam int unsigned DB   = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        ChangeFlag;

  int nChecks = 0;
  int nPass   = 0;

  mmio_port_controller_if bus();

  mmio_port_controller #(
    .MMIO_BASE       (BASE),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .PortIn     (PortIn),
    .PortOut    (PortOut),
    .ChangeFlag (ChangeFlag)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mPortOut;
  logic [7:0]  mStable;
  logic        mChange;
  logic [7:0]  hist1, hist2;
  logic [7:0]  runVal;
  int          runLen;

  task automatic modelReset();
    mPortOut = '0; mStable = '0; mChange = 1'b0;
    hist1 = '0; hist2 = '0; runVal = '0; runLen = 0;
  endtask

  function automatic logic refHit(input logic [31:0] a);
    return (a >= BASE) && (a - BASE < 32'd16) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a, input logic rd);
    if (!(rd && refHit(a))) return 32'h0;
    case ((a - BASE) / 4)
      0:       return mPortOut;
      1:       return {24'h0, mStable};
      2:       return {30'h0, (runLen > 0), mChange};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rd);
    bus.Address = a; bus.WriteData = wd; bus.MemWrite = we; bus.MemRead = rd;
  endtask

  // One clock edge: the model consumes the inputs present at the edge.
  task automatic tick();
    logic [7:0]  pin;
    logic [7:0]  sample;
    logic [31:0] a, wd;
    logic        we, acc;
    pin = PortIn; a = bus.Address; wd = bus.WriteData; we = bus.MemWrite;
    @(posedge clk);
    if (reset) begin
      modelReset();
    end else begin
      // The debouncer sees the input value from two edges earlier.
      sample = hist2; hist2 = hist1; hist1 = pin;
      acc = 1'b0;
      if (sample == mStable) runLen = 0;
      else if (runLen > 0 && sample == runVal) runLen++;
      else begin runVal = sample; runLen = 1; end
      if (runLen == DB) begin mStable = runVal; acc = 1'b1; runLen = 0; end
      if (we && refHit(a)) begin
        if (a - BASE == 0) mPortOut = wd;
        if (a - BASE == 8 && wd[0]) mChange = 1'b0;
      end
      if (acc) mChange = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; PortIn = 8'h00; drive(BASE + 4, 32'h0, 1'b0, 1'b1);
    modelReset();
    tick(); tick();
    nChecks++; if (PortOut !== 32'h0) $display("FAIL reset_portout got=%h exp=%h", PortOut, 32'h0); else nPass++;
    nChecks++; if (ChangeFlag !== 1'b0) $display("FAIL reset_change got=%b exp=0", ChangeFlag); else nPass++;
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL reset_portin got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_port_out();
    drive(BASE, 32'h0000_00A5, 1'b1, 1'b1);
    #1;
    nChecks++; if (bus.Hit !== 1'b1) $display("FAIL wr_hit got=%b exp=1", bus.Hit); else nPass++;
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL wr_read_old got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    tick();
    nChecks++; if (PortOut !== 32'hA5) $display("FAIL portout_a5 got=%h exp=%h", PortOut, 32'hA5); else nPass++;
    drive(BASE, 32'h0, 1'b0, 1'b1);
    #1;
    nChecks++; if (bus.ReadData !== 32'hA5) $display("FAIL read_a5 got=%h exp=%h", bus.ReadData, 32'hA5); else nPass++;
    drive(BASE + 4, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL portin_ro got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    nChecks++; if (PortOut !== 32'hA5) $display("FAIL portin_wr_keep got=%h exp=%h", PortOut, 32'hA5); else nPass++;
  endtask

  task automatic test_glitch();
    int busyCnt = 0;
    drive(BASE + 8, 32'h0, 1'b0, 1'b1);
    PortIn = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) PortIn = 8'h00;
      tick();
      if (bus.ReadData[1] === 1'b1) busyCnt++;
    end
    nChecks++; if (busyCnt != 3) $display("FAIL glitch_busy_cycles got=%0d exp=3", busyCnt); else nPass++;
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL glitch_status got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    nChecks++; if (ChangeFlag !== 1'b0) $display("FAIL glitch_change got=%b exp=0", ChangeFlag); else nPass++;
    drive(BASE + 4, 32'h0, 1'b0, 1'b1);
    #1;
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL glitch_portin got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
  endtask

  task automatic test_debounce_accept();
    drive(BASE + 4, 32'h0, 1'b0, 1'b1);
    PortIn = 8'h3C;
    for (int i = 0; i < 5; i++) tick();
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL accept_edge5 got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    tick();
    nChecks++; if (bus.ReadData !== 32'h3C) $display("FAIL accept_edge6 got=%h exp=%h", bus.ReadData, 32'h3C); else nPass++;
    nChecks++; if (ChangeFlag !== 1'b1) $display("FAIL accept_changeflag got=%b exp=1", ChangeFlag); else nPass++;
    drive(BASE + 8, 32'h0, 1'b0, 1'b1);
    #1;
    nChecks++; if (bus.ReadData !== 32'h1) $display("FAIL accept_status got=%h exp=%h", bus.ReadData, 32'h1); else nPass++;
  endtask

  task automatic test_w1c_collision();
    drive(BASE + 8, 32'h2, 1'b1, 1'b0);
    tick();
    nChecks++; if (ChangeFlag !== 1'b1) $display("FAIL w1c_bit0_zero got=%b exp=1", ChangeFlag); else nPass++;
    drive(BASE + 8, 32'h1, 1'b1, 1'b0);
    tick();
    nChecks++; if (ChangeFlag !== 1'b0) $display("FAIL w1c_clear got=%b exp=0", ChangeFlag); else nPass++;
    drive(BASE + 8, 32'h0, 1'b0, 1'b0);
    PortIn = 8'h5A;
    for (int i = 0; i < 5; i++) tick();
    drive(BASE + 8, 32'h1, 1'b1, 1'b0);
    tick();
    nChecks++; if (ChangeFlag !== 1'b1) $display("FAIL w1c_set_wins got=%b exp=1", ChangeFlag); else nPass++;
    drive(BASE + 4, 32'h0, 1'b0, 1'b1);
    #1;
    nChecks++; if (bus.ReadData !== 32'h5A) $display("FAIL w1c_portin got=%h exp=%h", bus.ReadData, 32'h5A); else nPass++;
    drive(BASE + 8, 32'h1, 1'b1, 1'b0);
    tick();
    nChecks++; if (ChangeFlag !== 1'b0) $display("FAIL w1c_later_clear got=%b exp=0", ChangeFlag); else nPass++;
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [3];
    addrs[0] = 32'h1001_0000; addrs[1] = 32'hFFFF_0002; addrs[2] = 32'hFFFF_0010;
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], 32'hDEAD_BEEF, 1'b1, 1'b1);
      #1;
      nChecks++; if (bus.Hit !== 1'b0) $display("FAIL oow_hit addr=%h got=%b exp=0", addrs[i], bus.Hit); else nPass++;
      nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL oow_read addr=%h got=%h exp=%h", addrs[i], bus.ReadData, 32'h0); else nPass++;
      tick();
      nChecks++; if (PortOut !== 32'hA5) $display("FAIL oow_portout addr=%h got=%h exp=%h", addrs[i], PortOut, 32'hA5); else nPass++;
    end
    drive(BASE + 12, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #1;
    nChecks++; if (bus.Hit !== 1'b1 || bus.ReadData !== 32'h0) $display("FAIL reserved got_hit=%b got_rd=%h exp_hit=1 exp_rd=%h", bus.Hit, bus.ReadData, 32'h0); else nPass++;
    tick();
    nChecks++; if (PortOut !== 32'hA5) $display("FAIL reserved_portout got=%h exp=%h", PortOut, 32'hA5); else nPass++;
  endtask

  task automatic test_reset_mid_count();
    drive(BASE, 32'hFF, 1'b1, 1'b0);
    tick();
    drive(BASE + 8, 32'h0, 1'b0, 1'b1);
    PortIn = 8'h77;
    for (int i = 0; i < 4; i++) tick();
    nChecks++; if (bus.ReadData !== 32'h2) $display("FAIL midcount_busy got=%h exp=%h", bus.ReadData, 32'h2); else nPass++;
    nChecks++; if (PortOut !== 32'hFF) $display("FAIL midcount_portout got=%h exp=%h", PortOut, 32'hFF); else nPass++;
    #2;
    reset = 1'b1;
    #1;
    nChecks++; if (PortOut !== 32'h0) $display("FAIL async_portout got=%h exp=%h", PortOut, 32'h0); else nPass++;
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL async_status got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    drive(BASE + 4, 32'h0, 1'b0, 1'b1);
    #1;
    nChecks++; if (bus.ReadData !== 32'h0) $display("FAIL async_portin got=%h exp=%h", bus.ReadData, 32'h0); else nPass++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    nChecks++; if (bus.ReadData !== 32'h77 || ChangeFlag !== 1'b1) $display("FAIL post_reset_accept got_rd=%h got_chg=%b exp_rd=%h exp_chg=1", bus.ReadData, ChangeFlag, 32'h77); else nPass++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] expRd;
    logic        expHit;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) PortIn = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: a = BASE;
        1: a = BASE + 4;
        2: a = BASE + 8;
        3: a = BASE + 12;
        4: a = BASE + 32'($urandom_range(1, 3));
        5: a = 32'h1001_0000 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      drive(a, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
      #1;
      expHit = refHit(a);
      expRd  = refRead(a, bus.MemRead);
      nChecks++; if (bus.Hit !== expHit) $display("FAIL rnd_hit i=%0d addr=%h got=%b exp=%b", i, a, bus.Hit, expHit); else nPass++;
      nChecks++; if (bus.ReadData !== expRd) $display("FAIL rnd_read i=%0d addr=%h got=%h exp=%h", i, a, bus.ReadData, expRd); else nPass++;
      tick();
      nChecks++; if (PortOut !== mPortOut) $display("FAIL rnd_portout i=%0d got=%h exp=%h", i, PortOut, mPortOut); else nPass++;
      nChecks++; if (ChangeFlag !== mChange) $display("FAIL rnd_change i=%0d got=%b exp=%b", i, ChangeFlag, mChange); else nPass++;
    end
  endtask

  initial begin
    test_reset();
    test_port_out();
    test_glitch();
    test_debounce_accept();
    test_w1c_collision();
    test_out_of_window();
    test_reset_mid_count();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
